// File: rtl/dm_wait_slave.sv
// Data-memory responder for the M-stage load/store port with configurable wait states.
// Latency: Ready pulses LATENCY+1 cycles after the acceptance edge; one transaction per LATENCY+2 cycles.
// Backpressure: Busy stalls the pipeline from the cycle after acceptance until the Ready cycle ends.
module dm_wait_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        mem_write_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic [31:0] read_data_o,
    output logic        addr_err_o,
    output logic        busy_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    busy_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    // Transaction view used at the commit edge: live inputs when committing
    // straight out of IDLE (zero latency), captured registers otherwise.
    logic                    cur_we;
    logic [3:0]              cur_be;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [31:0]             cur_wdata;
    logic                    cur_err;
    logic                    in_err;
    logic                    commit;

    // Reject out-of-range addresses, illegal lane patterns and misaligned halves/words.
    function automatic logic check_err(input logic [31:0] a, input logic [3:0] be);
        logic range_err;
        logic be_err;
        range_err = (a >> (ADDR_WIDTH + 2)) != 32'd0;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: be_err = 1'b0;
            4'b0011, 4'b1100:                   be_err = a[0];
            4'b1111:                            be_err = |a[1:0];
            default:                            be_err = 1'b1;
        endcase
        return range_err | be_err;
    endfunction

    assign in_err = check_err(addr_i, be_i);

    // Next-state logic: accept in IDLE, count wait states, single-cycle response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        be_d      = be_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        cur_we    = we_q;
        cur_be    = be_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_err   = err_q;
        case (state_q)
            S_IDLE: begin
                cur_we    = mem_write_i;
                cur_be    = be_i;
                cur_idx   = addr_i[ADDR_WIDTH+1:2];
                cur_wdata = write_data_i;
                cur_err   = in_err;
                if (req_i) begin
                    we_d    = mem_write_i;
                    be_d    = be_i;
                    idx_d   = addr_i[ADDR_WIDTH+1:2];
                    wdata_d = write_data_i;
                    err_d   = in_err;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        commit = (state_d == S_RESP) && (state_q != S_RESP);
    end

    // State, counter, captured transaction and registered Busy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Memory array: cleared on reset, byte-laned store on the edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (commit && cur_we && !cur_err) begin
            for (int l = 0; l < 4; l++) begin
                if (cur_be[l]) begin
                    mem_q[cur_idx][8*l +: 8] <= cur_wdata[8*l +: 8];
                end
            end
        end
    end

    // Read word: loaded on a good load, zeroed on error, held otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (commit) begin
            if (cur_err) begin
                rdata_q <= 32'd0;
            end else if (!cur_we) begin
                rdata_q <= mem_q[cur_idx];
            end
        end
    end

    assign ready_o     = (state_q == S_RESP);
    assign addr_err_o  = (state_q == S_RESP) && err_q;
    assign busy_o      = busy_q;
    assign read_data_o = rdata_q;

endmodule

// File: doc/dm_wait_slave.md
Name: dm_wait_slave

Overview:
- Data-memory responder for the pipeline's M-stage load/store port, replacing the zero-wait DM with a handshaked, configurable-latency memory.
- The core drives Req plus MemWrite/BE/Addr/WriteData as initiator; this block accepts the transaction, counts wait states, commits byte-laned writes or returns the read word, and pulses Ready.
- Busy feeds the hazard unit as an M-stage stall source.

Parameters:
- ADDR_WIDTH, 12, word-index bits; depth = 2**ADDR_WIDTH words.
- LATENCY, 2, wait cycles between acceptance and response (0..15 legal).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- Req  in  1  transaction request; held high by initiator until Ready
- MemWrite  in  1  1 = store, 0 = load; sampled at acceptance
- BE  in  4  byte-lane enables; sampled at acceptance
- Addr  in  32  byte address; sampled at acceptance
- WriteData  in  32  store data, lane-aligned; sampled at acceptance
- Ready  out  1  one-cycle response pulse
- ReadData  out  32  full read word, valid while Ready=1, held after
- AddrErr  out  1  qualifies Ready; transaction rejected
- Busy  out  1  1 while a transaction is accepted and not yet responded

Behaviour:
- Clock and Reset: one clock; reset is synchronous and active-low. When Reset=0 at a rising edge, the following hold:
  - State goes to IDLE; the counter is cleared.
  - Ready=0, AddrErr=0, Busy=0, ReadData=0.
  - All memory words are cleared to 0.
  - Any in-flight transaction is aborted with no write committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with Req=1, capture MemWrite/BE/Addr/WriteData into internal registers. This edge is the acceptance edge.
  - Check for errors at acceptance:
    - Addr[31:ADDR_WIDTH+2] != 0 is an error.
    - BE not in {0001,0010,0100,1000,0011,1100,1111} is an error.
    - BE=0011 or 1100 with Addr[0]=1 is an error.
    - BE=1111 with Addr[1:0] != 00 is an error.
  - Next state is WAIT with cnt=LATENCY-1 if LATENCY>0, otherwise RESP.
- WAIT:
  - cnt decrements each edge.
  - When cnt==0, next state is RESP.
  - Req/input changes are ignored (already captured).
- RESP:
  - Ready=1 for exactly this cycle.
  - On the RESP-exit edge, return to IDLE.
  - Ready is asserted in the cycle LATENCY+1 cycles after the acceptance edge.
- Busy=1 in WAIT and RESP, 0 in IDLE. Busy is a registered output and rises the cycle after acceptance.
- Store without error:
  - On the edge entering RESP, write each byte lane i where captured BE[i]=1 into mem[Addr[ADDR_WIDTH+1:2]].
  - Lanes with BE[i]=0 are unchanged.
  - ReadData is unchanged.
- Load without error:
  - On the edge entering RESP, ReadData <= full 32-bit word at the index, regardless of BE.
  - Sign/zero extension is done by the initiator.
- Error response:
  - Ready=1 and AddrErr=1 in RESP, with the same latency as a good transaction.
  - No memory write occurs; ReadData <= 0.
- AddrErr=0 whenever Ready=0.
- ReadData holds its value from the last load until the next load response, error, or reset.
- Back-to-back transactions:
  - If Req is still 1 in the IDLE cycle after RESP, that cycle's inputs are accepted as a new transaction.
  - The initiator must drop Req in the Ready cycle to avoid a repeat.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Req=0 in IDLE: no state change, no memory access.
- Memory is a register array, single-port; no read-during-write hazards arise because access is serialized by the FSM.

Test Plan:
- Reset/idle: hold Reset=0 for 2 cycles, then release. Required: Ready=0, Busy=0, ReadData=0, AddrErr=0; a load of Addr=0x0000_0010 with BE=1111 returns ReadData=0x0000_0000.
- Word store/load with LATENCY=2:
  - Store Addr=0x0000_0040, BE=1111, WriteData=0xDEAD_BEEF. Required: Busy rises 1 cycle after acceptance; Ready=1 exactly 3 cycles after acceptance.
  - Then load Addr=0x0000_0040, BE=1111. Required: ReadData=0xDEAD_BEEF while Ready=1.
- Byte lanes:
  - Store 0x1122_3344 with BE=1111 to Addr=0x80.
  - Store 0x0000_AA00 with BE=0010 to Addr=0x81.
  - Store 0xBBBB_0000 with BE=1100 to Addr=0x82.
  - Load Addr=0x80. Required: ReadData=0xBBBB_AA44.
- Errors:
  - Store with Addr=0x0000_4000 (ADDR_WIDTH=12). Required: Ready=1, AddrErr=1, ReadData=0.
  - Store with BE=1111 at Addr=0x0000_0042. Required: Ready=1, AddrErr=1.
  - Load of the targeted words. Required: unchanged.
  - Store with BE=0101. Required: AddrErr=1.
- Reset mid-operation: store 0x5555_5555 to Addr=0x20 with LATENCY=4, and assert Reset=0 during WAIT. Required: Busy=0 and Ready never pulses; a later load of Addr=0x20 returns 0.
- Back-to-back and LATENCY=0:
  - With Req held high across Ready, expect a second acceptance in the IDLE cycle after RESP.
  - Required at LATENCY=0: Ready appears 1 cycle after each acceptance, one transaction every 2 cycles.
